// File: rtl/mem_req_buffer_pkg.sv
// Shared constants and record layout helpers for the PE-to-memory request buffer.
// Data record, LSB first: be | wdata | we | addr.
package mem_req_buffer_pkg;

  localparam int DEPTH_DEF = 2;

  function automatic int f_lvlw(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int f_ptrw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int LVLW = f_lvlw(DEPTH_DEF);
  localparam int PTRW = f_ptrw(DEPTH_DEF);

  localparam int BE_LSB = 0;

  function automatic int wdata_lsb(input int dw);
    return dw / 8;
  endfunction

  function automatic int we_bit(input int dw);
    return dw / 8 + dw;
  endfunction

  function automatic int addr_lsb(input int dw);
    return dw / 8 + dw + 1;
  endfunction

endpackage

// File: rtl/mem_req_buffer_req_fifo.sv
// Single-channel request FIFO with level tracking and synchronous flush.
// The read port is forced to zero when empty so the memory side sees a clean bus.
module req_fifo
  import mem_req_buffer_pkg::*;
#(
  parameter int PW    = 32,
  parameter int DEPTH = 2,
  localparam int LW   = f_lvlw(DEPTH),
  localparam int PW2  = f_ptrw(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [PW-1:0] wdata,
  output logic [PW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [PW2-1:0] wptr, rptr;
  logic [PW-1:0]  mem [DEPTH];
  logic           do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rptr];

  // Flush wins over push/pop; a pop in the same cycle is already consumed downstream.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW2'(1);
      if (do_pop)  rptr <= rptr + PW2'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/mem_req_buffer.sv
// Per-PE instruction and data request FIFOs between the PEs and shared memory,
// with word-offset address relocation applied on the way in.
module mem_req_buffer
  import mem_req_buffer_pkg::*;
#(
  parameter int NUM_PE = 3,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int DEPTH  = 2,
  localparam int BW    = DW / 8,
  localparam int LW    = f_lvlw(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PE-1:0]    i_instr_req,
  input  logic [NUM_PE*AW-1:0] i_instr_addr,
  input  logic [NUM_PE*AW-1:0] i_instr_offset,
  input  logic [NUM_PE-1:0]    i_instr_flush,
  output logic [NUM_PE-1:0]    o_instr_gnt,
  input  logic [NUM_PE-1:0]    i_data_req,
  input  logic [NUM_PE-1:0]    i_data_we,
  input  logic [NUM_PE*AW-1:0] i_data_addr,
  input  logic [NUM_PE*DW-1:0] i_data_wdata,
  input  logic [NUM_PE*BW-1:0] i_data_be,
  input  logic [NUM_PE*AW-1:0] i_data_offset,
  output logic [NUM_PE-1:0]    o_data_gnt,
  output logic [NUM_PE-1:0]    o_instr_req,
  output logic [NUM_PE*AW-1:0] o_instr_addr,
  input  logic [NUM_PE-1:0]    i_mem_instr_gnt,
  output logic [NUM_PE-1:0]    o_data_req,
  output logic [NUM_PE-1:0]    o_data_we,
  output logic [NUM_PE*AW-1:0] o_data_addr,
  output logic [NUM_PE*DW-1:0] o_data_wdata,
  output logic [NUM_PE*BW-1:0] o_data_be,
  input  logic [NUM_PE-1:0]    i_mem_data_gnt,
  output logic [NUM_PE*LW-1:0] o_instr_level,
  output logic [NUM_PE*LW-1:0] o_data_level
);

  localparam int DPW   = AW + 1 + DW + BW;
  localparam int WD_LO = wdata_lsb(DW);
  localparam int WE_B  = we_bit(DW);
  localparam int AD_LO = addr_lsb(DW);

  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    logic          i_full, i_empty, i_push, i_pop;
    logic          d_full, d_empty, d_push, d_pop;
    logic [AW-1:0] i_reloc, d_reloc;
    logic [DPW-1:0] d_wr, d_rd;

    // Offsets are in words; top two offset bits fall off and wrap is silent.
    assign i_reloc = i_instr_addr[p*AW +: AW] + {i_instr_offset[p*AW +: AW-2], 2'b00};
    assign d_reloc = i_data_addr[p*AW +: AW]  + {i_data_offset[p*AW +: AW-2], 2'b00};

    assign o_instr_gnt[p] = i_rst_n & ~i_full & ~i_instr_flush[p];
    assign o_data_gnt[p]  = i_rst_n & ~d_full;
    assign i_push = i_instr_req[p] & o_instr_gnt[p];
    assign d_push = i_data_req[p] & o_data_gnt[p];
    assign i_pop  = ~i_empty & i_mem_instr_gnt[p];
    assign d_pop  = ~d_empty & i_mem_data_gnt[p];

    assign o_instr_req[p] = ~i_empty;
    assign o_data_req[p]  = ~d_empty;

    assign d_wr = {d_reloc, i_data_we[p], i_data_wdata[p*DW +: DW], i_data_be[p*BW +: BW]};

    assign o_data_be[p*BW +: BW]    = d_rd[BE_LSB +: BW];
    assign o_data_wdata[p*DW +: DW] = d_rd[WD_LO +: DW];
    assign o_data_we[p]             = d_rd[WE_B];
    assign o_data_addr[p*AW +: AW]  = d_rd[AD_LO +: AW];

    req_fifo #(.PW(AW), .DEPTH(DEPTH)) u_instr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (i_push),
      .pop     (i_pop),
      .flush   (i_instr_flush[p]),
      .wdata   (i_reloc),
      .rdata   (o_instr_addr[p*AW +: AW]),
      .full    (i_full),
      .empty   (i_empty),
      .level   (o_instr_level[p*LW +: LW])
    );

    req_fifo #(.PW(DPW), .DEPTH(DEPTH)) u_data (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (d_push),
      .pop     (d_pop),
      .flush   (1'b0),
      .wdata   (d_wr),
      .rdata   (d_rd),
      .full    (d_full),
      .empty   (d_empty),
      .level   (o_data_level[p*LW +: LW])
    );
  end

endmodule

// File: tb/tb_mem_req_buffer.sv
// Directed and random stimulus against a queue-based reference of every channel.
module tb_mem_req_buffer;
  localparam int NP = 3, AW = 32, DW = 32, BW = 4, DEPTH = 2, LW = 2;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_rst_n;
  logic [NP-1:0]    i_instr_req, i_instr_flush, o_instr_gnt, i_data_req, i_data_we, o_data_gnt;
  logic [NP*AW-1:0] i_instr_addr, i_instr_offset, i_data_addr, i_data_offset;
  logic [NP*DW-1:0] i_data_wdata;
  logic [NP*BW-1:0] i_data_be;
  logic [NP-1:0]    o_instr_req, i_mem_instr_gnt, o_data_req, o_data_we, i_mem_data_gnt;
  logic [NP*AW-1:0] o_instr_addr, o_data_addr;
  logic [NP*DW-1:0] o_data_wdata;
  logic [NP*BW-1:0] o_data_be;
  logic [NP*LW-1:0] o_instr_level, o_data_level;

  mem_req_buffer #(.NUM_PE(NP), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_instr_req(i_instr_req), .i_instr_addr(i_instr_addr), .i_instr_offset(i_instr_offset),
    .i_instr_flush(i_instr_flush), .o_instr_gnt(o_instr_gnt),
    .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
    .i_data_wdata(i_data_wdata), .i_data_be(i_data_be), .i_data_offset(i_data_offset),
    .o_data_gnt(o_data_gnt),
    .o_instr_req(o_instr_req), .o_instr_addr(o_instr_addr), .i_mem_instr_gnt(i_mem_instr_gnt),
    .o_data_req(o_data_req), .o_data_we(o_data_we), .o_data_addr(o_data_addr),
    .o_data_wdata(o_data_wdata), .o_data_be(o_data_be), .i_mem_data_gnt(i_mem_data_gnt),
    .o_instr_level(o_instr_level), .o_data_level(o_data_level)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic          we;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
  } dreq_t;

  logic [AW-1:0] iq [NP][$];
  dreq_t         dq [NP][$];
  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] reloc(input logic [AW-1:0] a, input logic [AW-1:0] off);
    return a + (off << 2);
  endfunction

  task automatic check_all();
    logic [NP-1:0] ig, dg, ir, dr, dwe;
    logic [NP*AW-1:0] ia, da;
    logic [NP*DW-1:0] dd;
    logic [NP*BW-1:0] dbe;
    logic [NP*LW-1:0] il, dl;
    ig = '0; dg = '0; ir = '0; dr = '0; dwe = '0; ia = '0; da = '0; dd = '0; dbe = '0;
    il = '0; dl = '0;
    for (int p = 0; p < NP; p++) begin
      ig[p] = i_rst_n && iq[p].size() < DEPTH && !i_instr_flush[p];
      dg[p] = i_rst_n && dq[p].size() < DEPTH;
      ir[p] = iq[p].size() != 0;
      dr[p] = dq[p].size() != 0;
      il[p*LW +: LW] = LW'(iq[p].size());
      dl[p*LW +: LW] = LW'(dq[p].size());
      if (ir[p]) ia[p*AW +: AW] = iq[p][0];
      if (dr[p]) begin
        da[p*AW +: AW] = dq[p][0].a;
        dwe[p]         = dq[p][0].we;
        dd[p*DW +: DW] = dq[p][0].d;
        dbe[p*BW +: BW] = dq[p][0].be;
      end
    end
    chk("instr_gnt", o_instr_gnt, ig);
    chk("data_gnt", o_data_gnt, dg);
    chk("instr_req", o_instr_req, ir);
    chk("instr_addr", o_instr_addr, ia);
    chk("instr_level", o_instr_level, il);
    chk("data_req", o_data_req, dr);
    chk("data_addr", o_data_addr, da);
    chk("data_we", o_data_we, dwe);
    chk("data_wdata", o_data_wdata, dd);
    chk("data_be", o_data_be, dbe);
    chk("data_level", o_data_level, dl);
  endtask

  // Settle, check against the model, advance the model by the inputs applied, then clock.
  task automatic step();
    #1;
    check_all();
    for (int p = 0; p < NP; p++) begin
      bit ipush, dpush;
      dreq_t e;
      ipush = i_instr_req[p] && iq[p].size() < DEPTH && !i_instr_flush[p];
      dpush = i_data_req[p] && dq[p].size() < DEPTH;
      if (iq[p].size() > 0 && i_mem_instr_gnt[p]) void'(iq[p].pop_front());
      if (dq[p].size() > 0 && i_mem_data_gnt[p]) void'(dq[p].pop_front());
      if (i_instr_flush[p]) iq[p].delete();
      else if (ipush) iq[p].push_back(reloc(i_instr_addr[p*AW +: AW], i_instr_offset[p*AW +: AW]));
      if (dpush) begin
        e.a  = reloc(i_data_addr[p*AW +: AW], i_data_offset[p*AW +: AW]);
        e.we = i_data_we[p];
        e.d  = i_data_wdata[p*DW +: DW];
        e.be = i_data_be[p*BW +: BW];
        dq[p].push_back(e);
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_instr_req = '0; i_instr_flush = '0; i_data_req = '0; i_data_we = '0;
    i_mem_instr_gnt = '0; i_mem_data_gnt = '0;
    i_instr_addr = '0; i_instr_offset = '0; i_data_addr = '0; i_data_offset = '0;
    i_data_wdata = '0; i_data_be = '0;
  endtask

  task automatic set_i(input int p, input bit req, input logic [AW-1:0] a, input logic [AW-1:0] off);
    i_instr_req[p] = req;
    i_instr_addr[p*AW +: AW] = a;
    i_instr_offset[p*AW +: AW] = off;
  endtask

  task automatic set_d(input int p, input bit req, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be, input logic [AW-1:0] off);
    i_data_req[p] = req;
    i_data_we[p] = we;
    i_data_addr[p*AW +: AW] = a;
    i_data_wdata[p*DW +: DW] = d;
    i_data_be[p*BW +: BW] = be;
    i_data_offset[p*AW +: AW] = off;
  endtask

  initial begin
    idle();
    i_rst_n = 1'b0;
    #1;
    check_all();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step();

    // Single instruction request with relocation
    set_i(0, 1, 32'h100, 32'h10);
    i_mem_instr_gnt[0] = 1'b1;
    step();
    set_i(0, 0, 0, 0);
    chk("single_addr", o_instr_addr[AW-1:0], 32'h140);
    step();
    chk("single_level", o_instr_level[LW-1:0], 0);
    idle();

    // Backpressure on PE1 data
    set_d(1, 1, 1, 32'h200, 32'hAAAA_0001, 4'h3, 32'h1); step();
    set_d(1, 1, 0, 32'h300, 32'hBBBB_0002, 4'hC, 32'h2); step();
    set_d(1, 1, 1, 32'h400, 32'hCCCC_0003, 4'hF, 32'h3);
    #1;
    chk("bp_gnt_full", o_data_gnt[1], 1'b0);
    chk("bp_level", o_data_level[LW +: LW], 2);
    step();
    i_mem_data_gnt[1] = 1'b1;
    chk("bp_head_a", o_data_wdata[DW +: DW], 32'hAAAA_0001);
    step();
    chk("bp_head_b", o_data_wdata[DW +: DW], 32'hBBBB_0002);
    step();
    set_d(1, 0, 0, 0, 0, 0, 0);
    chk("bp_head_c", o_data_addr[AW +: AW], 32'h40C);
    step();
    step();
    idle();

    // Address wrap
    set_i(2, 1, 32'hFFFF_FFFC, 32'h1); step();
    set_i(2, 0, 0, 0);
    chk("wrap_addr", o_instr_addr[2*AW +: AW], 32'h0);
    i_mem_instr_gnt[2] = 1'b1;
    step();
    idle();

    // Flush while the head is granted; data FIFO of same PE untouched
    set_i(0, 1, 32'h1000, 0);
    set_d(0, 1, 1, 32'h50, 32'h1234_5678, 4'h1, 0);
    step();
    set_d(0, 0, 0, 0, 0, 0, 0);
    set_i(0, 1, 32'h2000, 0); step();
    set_i(0, 0, 0, 0);
    i_instr_flush[0] = 1'b1;
    i_mem_instr_gnt[0] = 1'b1;
    #1;
    chk("flush_gnt", o_instr_gnt[0], 1'b0);
    chk("flush_head_req", o_instr_req[0], 1'b1);
    step();
    idle();
    chk("flush_req_after", o_instr_req[0], 1'b0);
    chk("flush_data_level", o_data_level[LW-1:0], 1);
    i_mem_data_gnt[0] = 1'b1;
    step();
    idle();

    // Simultaneous push/pop at level 1
    set_i(2, 1, 32'h3000, 0); step();
    i_mem_instr_gnt[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      set_i(2, 1, 32'h3000 + 32'(k * 4), 0);
      step();
      chk("pp_level", o_instr_level[2*LW +: LW], 1);
    end
    set_i(2, 0, 0, 0);
    step();
    idle();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        set_i(p, 1'($urandom), $urandom, $urandom);
        set_d(p, 1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom), $urandom);
        i_instr_flush[p]   = ($urandom_range(15) == 0);
        i_mem_instr_gnt[p] = 1'($urandom);
        i_mem_data_gnt[p]  = 1'($urandom);
      end
      step();
    end
    idle();

    // Async reset with every FIFO non-empty
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < NP; p++) begin
        set_i(p, 1, $urandom, $urandom);
        set_d(p, 1, 1, $urandom, $urandom, 4'hF, $urandom);
      end
      step();
    end
    idle();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_instr_req", o_instr_req, 0);
    chk("rst_data_req", o_data_req, 0);
    chk("rst_gnts", {o_instr_gnt, o_data_gnt}, 0);
    chk("rst_addrs", {o_instr_addr, o_data_addr}, 0);
    chk("rst_wdata", {o_data_we, o_data_wdata, o_data_be}, 0);
    chk("rst_levels", {o_instr_level, o_data_level}, 0);
    for (int p = 0; p < NP; p++) begin
      iq[p].delete();
      dq[p].delete();
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step();
    set_i(1, 1, 32'h80, 32'h2);
    step();
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_req_buffer.md
# mem_req_buffer

Parametrised request buffer between the NUM_PE processing elements and the shared instruction/data memory. Each PE has one instruction channel and one data channel, and each channel has its own DEPTH-entry FIFO. Addresses are relocated per PE at enqueue, and the instruction FIFO can be flushed per PE. Upstream and downstream use req/gnt handshakes, so the memory can stall a PE without losing or duplicating requests.

## Interface
- NUM_PE, 3, number of PEs; channels per PE = 2 (instr, data)
- AW, 32, address width
- DW, 32, data width; byte-enable width BW = DW/8
- DEPTH, 2, FIFO entries per channel; power of two, ≥ 2

- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_instr_req  in  NUM_PE  PE instruction request
- i_instr_addr  in  NUM_PE*AW  PE instruction address
- i_instr_offset  in  NUM_PE*AW  per-PE word offset for instruction relocation
- i_instr_flush  in  NUM_PE  synchronous flush of that PE's instruction FIFO
- o_instr_gnt  out  NUM_PE  upstream grant (request accepted)
- i_data_req / i_data_we  in  NUM_PE each  PE data request / write enable
- i_data_addr, i_data_wdata  in  NUM_PE*AW, NUM_PE*DW  data address, write data
- i_data_be  in  NUM_PE*BW  byte enables
- i_data_offset  in  NUM_PE*AW  per-PE word offset for data relocation
- o_data_gnt  out  NUM_PE  upstream grant
- o_instr_req, o_instr_addr  out  NUM_PE, NUM_PE*AW  request toward memory
- i_mem_instr_gnt  in  NUM_PE  memory grant
- o_data_req, o_data_we, o_data_addr, o_data_wdata, o_data_be  out  widths as the data inputs  request toward memory
- i_mem_data_gnt  in  NUM_PE  memory grant
- o_instr_level, o_data_level  out  NUM_PE*$clog2(DEPTH+1)  per-channel occupancy

## Operation
- Channels are independent; there is no interaction between PEs or between the instr and data channels.
- Upstream grant: o_*_gnt = i_rst_n & ~full. For instr, also & ~i_instr_flush.
- Enqueue when i_*_req & o_*_gnt.
  - Stored address = i_addr + {i_offset[AW-3:0], 2'b00}, computed modulo 2^AW; wrap-around is silent.
  - The offset is sampled at enqueue and is not re-read later.
- Downstream output: o_*_req = ~empty. Address, we, wdata and be show the head entry. When empty, all of these are driven 0.
- Dequeue when o_*_req & i_mem_*_gnt.
  - The head is held stable until it is granted.
  - i_mem_*_gnt while empty is ignored.
- Simultaneous enqueue and dequeue: allowed when not full. Level is unchanged. Pointers advance modulo DEPTH.
- Full: gnt is deasserted combinationally. An enqueue is never accepted in the same cycle that a dequeue frees a slot.
- Flush (instr only): at the clock edge, pointers and level for that PE clear to 0.
  - A dequeue in the flush cycle still completes, because the memory has sampled it.
  - o_instr_req is 0 from the next cycle.
  - The data FIFO is unaffected.
- Reset (asynchronous, including mid-operation): all FIFOs empty; every output 0 (gnt 0 while reset is held, 1 after release); entries in flight are discarded.

## Timing
- Latency from upstream accept at edge N to o_*_req asserted: 1 cycle (visible after edge N).
- Throughput: 1 request per cycle per channel while the memory grants every cycle.
- o_*_gnt depends combinationally on FIFO state (and flush) only, never on i_*_req. All memory-side outputs are driven directly from FIFO registers.
- Level updates at the same edge as the push/pop.

## Structure
- Shared package holds:
  - localparams for LVLW = $clog2(DEPTH+1) and PTRW = $clog2(DEPTH)
  - request-record field offsets (addr, we, wdata, be)
- One sub-module, req_fifo, parametrised on payload width and DEPTH, with push/pop/flush/full/empty/level.
- The top instantiates 2*NUM_PE req_fifo copies in a generate loop. Instr payload is AW bits; data payload is AW+1+DW+BW bits.
- Relocation adders sit at the top, before each push.

## Test plan
- Single instr req: PE0 addr 0x100, offset 0x10, memory gnt held 1 -> o_instr_addr[0] = 0x140 one cycle later, req drops the cycle after the grant, level back to 0.
- Backpressure: PE1 data writes A, B, C with i_mem_data_gnt = 0 and DEPTH = 2 -> gnt drops after B, level = 2. Release gnt -> A then B presented in order with unchanged wdata/be, then C accepted.
- Wrap: addr 0xFFFF_FFFC, offset 1 -> output addr 0x0000_0000.
- Flush: two instr entries queued, flush pulsed in the same cycle as a memory grant of the head -> head counted as dequeued, o_instr_req = 0 next cycle, gnt = 0 in the flush cycle, data FIFO level unchanged.
- Simultaneous push/pop at level 1 for 10 cycles -> level stays 1, addresses emerge in order, none lost.
- Async reset asserted mid-stream with all FIFOs non-empty -> all outputs 0 immediately, gnt 1 on the first edge-free cycle after release, levels 0.
